adder_fail_logger: RTL

ADDER_FAIL_LOGGER -- requirements
Module: adder_fail_logger

---
 rtl/adder_fail_logger.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adder_fail_logger.sv
// Adder mismatch logger: mismatch statistics, first-failure capture and a 9-byte serial dump.
// Optional macro ADDER_LOG_AUTODUMP_EN starts a dump automatically on the first capture.
module adder_fail_logger #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [13:0]      adder_operand1,
  input  logic [13:0]      adder_operand2,
  input  logic [14:0]      structural_sum,
  input  logic [14:0]      behavioral_sum,
  input  logic             clear,
  input  logic             dump_req,
  output logic             fail_seen,
  output logic [CNT_W-1:0] mismatch_count,
  output logic             sweep_done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sweep_q, sweep_d;
  logic [13:0]      recOp1_q, recOp1_d, recOp2_q, recOp2_d;
  logic [14:0]      recSt_q, recSt_d, recBh_q, recBh_d;
  logic             snapFail_q;
  logic [13:0]      snapOp1_q, snapOp2_q;
  logic [14:0]      snapSt_q, snapBh_q;
  logic             mismatch, sweepHit, firstMiss, startDump, loadSnap;

  assign mismatch  = in_valid && (structural_sum != behavioral_sum);
  assign sweepHit  = in_valid && (adder_operand1 == 14'h3FFF) && (adder_operand2 == 14'h3FFF);
  assign firstMiss = mismatch && (clear || !fail_q);

`ifdef ADDER_LOG_AUTODUMP_EN
  logic autoReq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) autoReq_q <= 1'b0;
    else        autoReq_q <= firstMiss;
  end

  assign startDump = dump_req || autoReq_q;
`else
  assign startDump = dump_req;
`endif

  // Clear is applied first so a same-cycle sample still lands in fresh statistics.
  always_comb begin
    fail_d   = clear ? 1'b0 : fail_q;
    count_d  = clear ? '0 : count_q;
    sweep_d  = clear ? 1'b0 : sweep_q;
    recOp1_d = clear ? '0 : recOp1_q;
    recOp2_d = clear ? '0 : recOp2_q;
    recSt_d  = clear ? '0 : recSt_q;
    recBh_d  = clear ? '0 : recBh_q;
    if (mismatch) begin
      fail_d = 1'b1;
      if (count_d != {CNT_W{1'b1}}) count_d = count_d + CNT_W'(1);
    end
    if (firstMiss) begin
      recOp1_d = adder_operand1;
      recOp2_d = adder_operand2;
      recSt_d  = structural_sum;
      recBh_d  = behavioral_sum;
    end
    if (sweepHit) sweep_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    loadSnap = 1'b0;
    case (state_q)
      IDLE: begin
        if (startDump) begin
          state_d  = SEND;
          idx_d    = 4'd0;
          loadSnap = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == 4'd8) begin
            state_d = IDLE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      fail_q     <= 1'b0;
      count_q    <= '0;
      sweep_q    <= 1'b0;
      recOp1_q   <= '0;
      recOp2_q   <= '0;
      recSt_q    <= '0;
      recBh_q    <= '0;
      snapFail_q <= 1'b0;
      snapOp1_q  <= '0;
      snapOp2_q  <= '0;
      snapSt_q   <= '0;
      snapBh_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      fail_q   <= fail_d;
      count_q  <= count_d;
      sweep_q  <= sweep_d;
      recOp1_q <= recOp1_d;
      recOp2_q <= recOp2_d;
      recSt_q  <= recSt_d;
      recBh_q  <= recBh_d;
      if (loadSnap) begin
        snapFail_q <= fail_q;
        snapOp1_q  <= recOp1_q;
        snapOp2_q  <= recOp2_q;
        snapSt_q   <= recSt_q;
        snapBh_q   <= recBh_q;
      end
    end
  end

  // The frame is served purely from the snapshot so clears mid-frame cannot tear it.
  always_comb begin
    out_data = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    out_data = snapFail_q ? 8'hA5 : 8'h5A;
        4'd1:    out_data = {2'b00, snapOp1_q[13:8]};
        4'd2:    out_data = snapOp1_q[7:0];
        4'd3:    out_data = {2'b00, snapOp2_q[13:8]};
        4'd4:    out_data = snapOp2_q[7:0];
        4'd5:    out_data = {1'b0, snapSt_q[14:8]};
        4'd6:    out_data = snapSt_q[7:0];
        4'd7:    out_data = {1'b0, snapBh_q[14:8]};
        4'd8:    out_data = snapBh_q[7:0];
        default: out_data = 8'h00;
      endcase
    end
  end

  assign out_valid      = (state_q == SEND);
  assign fail_seen      = fail_q;
  assign mismatch_count = count_q;
  assign sweep_done     = sweep_q;

endmodule
